// File: rtl/demux4_stream_if.sv
// Stream bundle for demux4_stream: one upstream port fanned out to four channels.
// The DUT uses the slave modport and the producer/consumer side uses master.
interface demux4_stream_if #(
  parameter int unsigned WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [1:0]         in_sel;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic [4*WIDTH-1:0] out_data;
  logic [31:0]        out_cnt;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, out_cnt
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, out_cnt
  );
endinterface

// File: rtl/demux4_stream.sv
// 1-to-4 stream demultiplexer: one holding register and one 8-bit accept counter per channel.
// in_ready is combinational from the selected channel only, so other channels never block.
module demux4_stream #(
  parameter int unsigned WIDTH = 8
) (
  input logic            clk,
  input logic            rst,
  demux4_stream_if.slave bus
);

  logic [3:0]            valid_q, valid_d;
  logic [3:0][WIDTH-1:0] data_q, data_d;
  logic [3:0][7:0]       cnt_q, cnt_d;
  logic                  accept;

  assign bus.in_ready = ~valid_q[bus.in_sel] | bus.out_ready[bus.in_sel];
  assign accept       = bus.in_valid & bus.in_ready;

  // A load into a draining channel reloads it in the same cycle, so there is no bubble.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    for (int unsigned k = 0; k < 4; k++) begin
      if (accept && (bus.in_sel == 2'(k))) begin
        valid_d[k] = 1'b1;
        data_d[k]  = bus.in_data;
        cnt_d[k]   = cnt_q[k] + 8'd1;
      end else if (valid_q[k] && bus.out_ready[k]) begin
        valid_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_cnt   = cnt_q;

endmodule

// File: tb/tb_demux4_stream.sv
// Directed bench for demux4_stream: a vector table for routing, backpressure and independence,
// plus hand-written sequences for async reset and counter wrap.
module tb_demux4_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  demux4_stream_if #(.WIDTH(8)) bus ();

  demux4_stream #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        iv;
    logic [1:0]  sel;
    logic [7:0]  d;
    logic [3:0]  ordy;
    logic        exp_rdy;
    logic [3:0]  exp_ov;
    logic [31:0] exp_od;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [1:0] sel, input logic [7:0] d,
                       input logic [3:0] ordy);
    bus.in_valid  = iv;
    bus.in_sel    = sel;
    bus.in_data   = d;
    bus.out_ready = ordy;
  endtask

  // Drive at the negedge, check in_ready before the edge, check registers #1 after it.
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    drive(v.iv, v.sel, v.d, v.ordy);
    #1;
    check($sformatf("v%0d in_ready", idx), 32'(bus.in_ready), 32'(v.exp_rdy));
    @(posedge clk);
    #1;
    check($sformatf("v%0d out_valid", idx), 32'(bus.out_valid), 32'(v.exp_ov));
    check($sformatf("v%0d out_data", idx), bus.out_data, v.exp_od);
    check($sformatf("v%0d out_cnt", idx), bus.out_cnt, v.exp_cnt);
  endtask

  initial begin
    //            iv    sel   data   ordy  rdy   ov    out_data      out_cnt
    vecs[0]  = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'h0, 32'h0000_0000, 32'h0000_0000};
    // basic route to ch2, valid for exactly one cycle
    vecs[1]  = '{1'b1, 2'd2, 8'hA5, 4'hF, 1'b1, 4'h4, 32'h00A5_0000, 32'h0001_0000};
    vecs[2]  = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'h0, 32'h00A5_0000, 32'h0001_0000};
    // backpressure on ch1
    vecs[3]  = '{1'b1, 2'd1, 8'h11, 4'h0, 1'b1, 4'h2, 32'h00A5_1100, 32'h0001_0100};
    vecs[4]  = '{1'b1, 2'd1, 8'h22, 4'h0, 1'b0, 4'h2, 32'h00A5_1100, 32'h0001_0100};
    vecs[5]  = '{1'b1, 2'd1, 8'h22, 4'h0, 1'b0, 4'h2, 32'h00A5_1100, 32'h0001_0100};
    vecs[6]  = '{1'b1, 2'd1, 8'h22, 4'h2, 1'b1, 4'h2, 32'h00A5_2200, 32'h0001_0200};
    vecs[7]  = '{1'b0, 2'd1, 8'h00, 4'h2, 1'b1, 4'h0, 32'h00A5_2200, 32'h0001_0200};
    // concurrent drain and reload on ch0
    vecs[8]  = '{1'b1, 2'd0, 8'h01, 4'h0, 1'b1, 4'h1, 32'h00A5_2201, 32'h0001_0201};
    vecs[9]  = '{1'b1, 2'd0, 8'h02, 4'h1, 1'b1, 4'h1, 32'h00A5_2202, 32'h0001_0202};
    // ch3 stalled, ch0 still flows
    vecs[10] = '{1'b1, 2'd3, 8'h77, 4'h0, 1'b1, 4'h9, 32'h77A5_2202, 32'h0101_0202};
    vecs[11] = '{1'b0, 2'd3, 8'h00, 4'h1, 1'b0, 4'h8, 32'h77A5_2202, 32'h0101_0202};
    vecs[12] = '{1'b1, 2'd0, 8'h33, 4'h0, 1'b1, 4'h9, 32'h77A5_2233, 32'h0101_0203};
    // in_sel/in_data ignored while in_valid is low; in_ready follows in_sel
    vecs[13] = '{1'b0, 2'd0, 8'hFF, 4'h0, 1'b0, 4'h9, 32'h77A5_2233, 32'h0101_0203};
    vecs[14] = '{1'b0, 2'd1, 8'hEE, 4'h0, 1'b1, 4'h9, 32'h77A5_2233, 32'h0101_0203};
    vecs[15] = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'h0, 32'h77A5_2233, 32'h0101_0203};

    drive(1'b0, 2'd0, 8'h00, 4'hF);
    #1;
    check("reset out_valid", 32'(bus.out_valid), 32'h0);
    check("reset out_data", bus.out_data, 32'h0);
    check("reset out_cnt", bus.out_cnt, 32'h0);
    check("reset in_ready", 32'(bus.in_ready), 32'h1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) apply(vecs[i], i);

    // Fill all four channels, then assert reset between edges.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(1'b1, 2'(k), 8'(8'hC0 + k), 4'h0);
      @(posedge clk);
    end
    #1;
    check("fill out_valid", 32'(bus.out_valid), 32'hF);
    @(negedge clk);
    drive(1'b1, 2'd0, 8'h99, 4'h0);
    #2;
    rst = 1'b1;
    #1;
    check("async rst out_valid", 32'(bus.out_valid), 32'h0);
    check("async rst out_data", bus.out_data, 32'h0);
    check("async rst out_cnt", bus.out_cnt, 32'h0);
    check("async rst in_ready", 32'(bus.in_ready), 32'h1);
    // in_valid held high across an edge while in reset must not load
    @(posedge clk);
    #1;
    check("rst edge out_valid", 32'(bus.out_valid), 32'h0);
    check("rst edge out_cnt", bus.out_cnt, 32'h0);

    // 256 back-to-back accepts into ch2, the first on the first edge after reset release.
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 2'd2, 8'(i), 4'hF);
      @(posedge clk);
      #1;
      if (i == 0) begin
        check("first accept out_valid", 32'(bus.out_valid), 32'h4);
        check("first accept out_cnt", bus.out_cnt, 32'h0001_0000);
      end
      if (i == 254) check("cnt at 255", bus.out_cnt, 32'h00FF_0000);
      if (i == 255) begin
        check("cnt wrap", bus.out_cnt, 32'h0000_0000);
        check("wrap out_data", bus.out_data, 32'h00FF_0000);
        check("wrap out_valid", 32'(bus.out_valid), 32'h4);
      end
      @(negedge clk);
    end
    drive(1'b0, 2'd0, 8'h00, 4'hF);
    @(posedge clk);
    #1;
    check("final out_valid", 32'(bus.out_valid), 32'h0);
    check("final out_cnt", bus.out_cnt, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
